// File: rtl/br_resolve_collector.sv
// Collects branch results from the execute lanes, drops wrong-path results by age,
// and issues a single-cycle global-history recovery for the oldest mispredict.
module br_resolve_collector #(
    parameter int ISSUE_WIDTH     = 2,
    parameter int GH_WIDTH        = 10,
    parameter int PHT_IDX_WIDTH   = 11,
    parameter int PHT_ENTRY_WIDTH = 2,
    parameter int AGE_WIDTH       = 7
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ISSUE_WIDTH-1:0]               in_valid,
    input  logic [ISSUE_WIDTH-1:0]               in_mispred,
    input  logic [ISSUE_WIDTH-1:0]               in_is_cond,
    input  logic [ISSUE_WIDTH-1:0]               in_exec_taken,
    input  logic [ISSUE_WIDTH*GH_WIDTH-1:0]        in_gh,
    input  logic [ISSUE_WIDTH*PHT_IDX_WIDTH-1:0]   in_pht_idx,
    input  logic [ISSUE_WIDTH*PHT_ENTRY_WIDTH-1:0] in_pht_prev,
    input  logic [ISSUE_WIDTH*AGE_WIDTH-1:0]       in_age,
    input  logic                                 flush_done,
    output logic [ISSUE_WIDTH-1:0]               out_valid,
    output logic [ISSUE_WIDTH-1:0]               out_mispred,
    output logic [ISSUE_WIDTH-1:0]               out_exec_taken,
    output logic [ISSUE_WIDTH*PHT_IDX_WIDTH-1:0]   out_pht_idx,
    output logic [ISSUE_WIDTH*PHT_ENTRY_WIDTH-1:0] out_pht_prev,
    output logic                                 recover_valid,
    output logic [GH_WIDTH-1:0]                  recover_history,
    output logic                                 recovering,
    output logic [15:0]                          recover_count
);

    typedef enum logic [1:0] {IDLE, RECOVER, DRAIN} state_t;

    state_t                 state, stateNext;
    logic [AGE_WIDTH-1:0]   storedAge;
    logic [ISSUE_WIDTH-1:0] ageOk, survive;
    logic                   haveSel;
    logic [AGE_WIDTH-1:0]   selAge, laneAge;
    logic [GH_WIDTH-1:0]    selHist, laneGh;

    // Circular compare: a is older than b when b lies less than half the tag space ahead of a.
    function automatic logic isOlder(input logic [AGE_WIDTH-1:0] a, input logic [AGE_WIDTH-1:0] b);
        logic [AGE_WIDTH-1:0] diff;
        diff = b - a;
        return (a != b) && !diff[AGE_WIDTH-1];
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ageOk     = '0;
        survive   = '0;
        haveSel   = 1'b0;
        selAge    = '0;
        selHist   = '0;
        laneAge   = '0;
        laneGh    = '0;
        stateNext = state;

        // Strictly-older test keeps the lower lane on an age tie.
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            laneAge  = in_age[i*AGE_WIDTH +: AGE_WIDTH];
            laneGh   = in_gh[i*GH_WIDTH +: GH_WIDTH];
            ageOk[i] = (state == IDLE) || isOlder(laneAge, storedAge);
            if (in_valid[i] && in_mispred[i] && ageOk[i] && (!haveSel || isOlder(laneAge, selAge))) begin
                haveSel = 1'b1;
                selAge  = laneAge;
                selHist = in_is_cond[i] ? {laneGh[GH_WIDTH-2:0], in_exec_taken[i]} : laneGh;
            end
        end

        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            laneAge    = in_age[i*AGE_WIDTH +: AGE_WIDTH];
            survive[i] = in_valid[i] && ageOk[i] && (!haveSel || !isOlder(selAge, laneAge));
        end

        case (state)
            IDLE:    if (haveSel) stateNext = RECOVER;
            RECOVER: stateNext = haveSel ? RECOVER : DRAIN;
            DRAIN: begin
                if (haveSel)         stateNext = RECOVER;
                else if (flush_done) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            storedAge       <= '0;
            out_valid       <= '0;
            out_mispred     <= '0;
            out_exec_taken  <= '0;
            out_pht_idx     <= '0;
            out_pht_prev    <= '0;
            recover_valid   <= 1'b0;
            recover_history <= '0;
            recovering      <= 1'b0;
            recover_count   <= '0;
        end else begin
            state          <= stateNext;
            out_valid      <= survive;
            out_mispred    <= in_mispred;
            out_exec_taken <= in_exec_taken;
            out_pht_idx    <= in_pht_idx;
            out_pht_prev   <= in_pht_prev;
            recover_valid  <= haveSel;
            recovering     <= (stateNext != IDLE);
            if (haveSel) begin
                storedAge       <= selAge;
                recover_history <= selHist;
                if (recover_count != 16'hFFFF)
                    recover_count <= recover_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_br_resolve_collector.sv
// Randomized and directed bench for br_resolve_collector against an age-rule reference model.
module tb_br_resolve_collector;

    localparam int IW = 2;
    localparam int GW = 10;
    localparam int PW = 11;
    localparam int EW = 2;
    localparam int AW = 7;
    localparam int AMOD = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [IW-1:0]   in_valid, in_mispred, in_is_cond, in_exec_taken;
    logic [IW*GW-1:0] in_gh;
    logic [IW*PW-1:0] in_pht_idx;
    logic [IW*EW-1:0] in_pht_prev;
    logic [IW*AW-1:0] in_age;
    logic            flush_done;
    logic [IW-1:0]   out_valid, out_mispred, out_exec_taken;
    logic [IW*PW-1:0] out_pht_idx;
    logic [IW*EW-1:0] out_pht_prev;
    logic            recover_valid;
    logic [GW-1:0]   recover_history;
    logic            recovering;
    logic [15:0]     recover_count;

    br_resolve_collector dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mispred(in_mispred), .in_is_cond(in_is_cond),
        .in_exec_taken(in_exec_taken), .in_gh(in_gh), .in_pht_idx(in_pht_idx),
        .in_pht_prev(in_pht_prev), .in_age(in_age), .flush_done(flush_done),
        .out_valid(out_valid), .out_mispred(out_mispred), .out_exec_taken(out_exec_taken),
        .out_pht_idx(out_pht_idx), .out_pht_prev(out_pht_prev),
        .recover_valid(recover_valid), .recover_history(recover_history),
        .recovering(recovering), .recover_count(recover_count)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: 0 = idle, 1 = recovering (pulse), 2 = draining
    int mState = 0;
    int mAge   = 0;
    int mCount = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit older(input int a, input int b);
        return (a != b) && (((b - a) % AMOD + AMOD) % AMOD < AMOD / 2);
    endfunction

    task automatic clearLanes();
        in_valid = '0; in_mispred = '0; in_is_cond = '0; in_exec_taken = '0;
        in_gh = '0; in_pht_idx = '0; in_pht_prev = '0; in_age = '0; flush_done = 1'b0;
    endtask

    task automatic setLane(input int i, input bit v, input bit m, input bit c, input bit t,
                           input int gh, input int idx, input int prev, input int age);
        in_valid[i] = v; in_mispred[i] = m; in_is_cond[i] = c; in_exec_taken[i] = t;
        in_gh[i*GW +: GW]       = GW'(gh);
        in_pht_idx[i*PW +: PW]  = PW'(idx);
        in_pht_prev[i*EW +: EW] = EW'(prev);
        in_age[i*AW +: AW]      = AW'(age);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearLanes();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mState = 0; mAge = 0; mCount = 0;
    endtask

    // Apply current inputs for one clock (called at negedge) and compare registered outputs.
    task automatic cycle();
        int  selAge, selLane, age, gh;
        bit  have;
        logic [IW-1:0] expValid;
        logic [GW-1:0] expHist;
        have = 0; selAge = 0; selLane = 0; expValid = '0; expHist = '0;
        for (int i = 0; i < IW; i++) begin
            age = int'(in_age[i*AW +: AW]);
            if (in_valid[i] && in_mispred[i] && (mState == 0 || older(age, mAge)))
                if (!have || older(age, selAge)) begin
                    have = 1; selAge = age; selLane = i;
                end
        end
        for (int i = 0; i < IW; i++) begin
            age = int'(in_age[i*AW +: AW]);
            expValid[i] = in_valid[i] && (mState == 0 || older(age, mAge)) && !(have && older(selAge, age));
        end
        if (have) begin
            gh = int'(in_gh[selLane*GW +: GW]);
            expHist = in_is_cond[selLane] ? GW'(gh * 2 + int'(in_exec_taken[selLane])) : GW'(gh);
            mAge = selAge;
            mState = 1;
            if (mCount < 16'hFFFF) mCount++;
        end else if (mState == 1) mState = 2;
        else if (mState == 2 && flush_done) mState = 0;

        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(expValid));
        for (int i = 0; i < IW; i++)
            if (expValid[i]) begin
                check("out_pht_idx",  32'(out_pht_idx[i*PW +: PW]),  32'(in_pht_idx[i*PW +: PW]));
                check("out_pht_prev", 32'(out_pht_prev[i*EW +: EW]), 32'(in_pht_prev[i*EW +: EW]));
                check("out_taken",    32'(out_exec_taken[i]),        32'(in_exec_taken[i]));
                check("out_mispred",  32'(out_mispred[i]),           32'(in_mispred[i]));
            end
        check("recover_valid", 32'(recover_valid), 32'(have));
        if (have) check("recover_history", 32'(recover_history), 32'(expHist));
        check("recovering", 32'(recovering), 32'(mState != 0));
        check("recover_count", 32'(recover_count), 32'(mCount));
        @(negedge clk);
        clearLanes();
    endtask

    initial begin
        int a0, a1;
        rst_n = 1'b0;
        clearLanes();
        #2;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_recovering", 32'(recovering), 0);
        check("reset_count", 32'(recover_count), 0);
        @(negedge clk);
        doReset();

        // Plain forward in IDLE
        setLane(0, 1, 0, 1, 1, 0, 'h155, 2, 3);
        cycle();
        check("t1_idx", 32'(out_pht_idx[PW-1:0]), 'h155);

        // Lane1 conditional mispredict selected; younger lane0 dropped
        setLane(1, 1, 1, 1, 0, 'h2A5, 'h10, 1, 10);
        setLane(0, 1, 0, 1, 1, 'h000, 'h20, 3, 12);
        cycle();
        check("t2_hist", 32'(recover_history), 'h14A);
        check("t2_valid", 32'(out_valid), 2);
        check("t2_count", 32'(recover_count), 1);

        // Two mispredicts, lane1 older
        doReset();
        setLane(0, 1, 1, 1, 1, 'h0F0, 'h1, 0, 7);
        setLane(1, 1, 1, 1, 1, 'h111, 'h2, 1, 5);
        cycle();
        check("t3_valid", 32'(out_valid), 2);
        check("t3_hist", 32'(recover_history), 'h223);
        cycle();
        check("t3_single_pulse", 32'(recover_valid), 0);

        // DRAIN at age 20, older mispredict plus flush_done re-enters RECOVER
        doReset();
        setLane(0, 1, 1, 0, 0, 'h3FF, 0, 0, 20);
        cycle();
        cycle();
        setLane(0, 1, 1, 1, 1, 'h001, 0, 0, 18);
        flush_done = 1'b1;
        cycle();
        check("t4_count", 32'(recover_count), 2);
        setLane(0, 1, 0, 0, 0, 0, 'h7, 0, 19);
        cycle();
        check("t4_dropped", 32'(out_valid), 0);

        // Wrap-around: stored age 126
        doReset();
        setLane(0, 1, 1, 0, 1, 'h055, 0, 0, 126);
        cycle();
        cycle();
        setLane(0, 1, 0, 0, 0, 0, 'h1, 0, 1);
        setLane(1, 1, 0, 0, 0, 0, 'h2, 0, 125);
        cycle();
        check("t5_wrap_valid", 32'(out_valid), 2);
        flush_done = 1'b1;
        cycle();
        check("t5_idle", 32'(recovering), 0);

        // Async reset while in RECOVER
        doReset();
        setLane(0, 1, 1, 1, 1, 'h0AA, 'h3, 0, 40);
        setLane(1, 1, 0, 0, 0, 0, 'h4, 0, 30);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rv_async", 32'(recover_valid), 0);
        check("t6_valid_async", 32'(out_valid), 0);
        check("t6_rec_async", 32'(recovering), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mState = 0; mAge = 0; mCount = 0;
        cycle();
        check("t6_count", 32'(recover_count), 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            a0 = int'($urandom_range(0, AMOD - 1));
            a1 = (a0 + int'($urandom_range(1, AMOD - 1))) % AMOD;
            setLane(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 3)), a0);
            setLane(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 3)), a1);
            flush_done = $urandom_range(0, 2) == 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/br_resolve_collector.md
Name: br_resolve_collector

Overview:
- Sits between the integer-execute branch pipes and the gshare predictor.
- Registers branch results from ISSUE_WIDTH execute lanes and filters wrong-path results by age.
- Selects the oldest mispredicted branch and issues a one-cycle history-recovery request.
- Forwards surviving results to the predictor's PHT-update and recovery inputs.

Parameters:
ISSUE_WIDTH, 2, number of integer execute lanes delivering branch results
GH_WIDTH, 10, global branch history width
PHT_IDX_WIDTH, 11, PHT index width
PHT_ENTRY_WIDTH, 2, PHT saturating counter width
AGE_WIDTH, 7, instruction age tag width (ROB index plus wrap bit), compared circularly

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  ISSUE_WIDTH  lane carries a resolved branch
in_mispred  in  ISSUE_WIDTH  lane branch was mispredicted
in_is_cond  in  ISSUE_WIDTH  lane branch is conditional
in_exec_taken  in  ISSUE_WIDTH  executed direction
in_gh  in  ISSUE_WIDTH*GH_WIDTH  history captured at prediction, lane i at [i*GH_WIDTH +: GH_WIDTH]
in_pht_idx  in  ISSUE_WIDTH*PHT_IDX_WIDTH  PHT index used at prediction
in_pht_prev  in  ISSUE_WIDTH*PHT_ENTRY_WIDTH  PHT counter value read at prediction
in_age  in  ISSUE_WIDTH*AGE_WIDTH  age tag
flush_done  in  1  backend has finished squashing the wrong path
out_valid  out  ISSUE_WIDTH  forwarded result valid (drives PHT write enable)
out_mispred  out  ISSUE_WIDTH  forwarded mispred flag
out_exec_taken  out  ISSUE_WIDTH  forwarded direction
out_pht_idx  out  ISSUE_WIDTH*PHT_IDX_WIDTH  forwarded PHT index
out_pht_prev  out  ISSUE_WIDTH*PHT_ENTRY_WIDTH  forwarded previous counter value
recover_valid  out  1  one-cycle pulse: predictor must load recover_history
recover_history  out  GH_WIDTH  corrected global history
recovering  out  1  high while the state is RECOVER or DRAIN
recover_count  out  16  saturating count of recover_valid pulses

Behaviour:
- Single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset clears all outputs to 0, sets the state to IDLE and clears the stored age.
- All outputs are registered. Results appear exactly 1 cycle after input.

Age rules:
- a is older than b iff a != b and ((b - a) mod 2^AGE_WIDTH) < 2^(AGE_WIDTH-1).
- Equal ages never occur on simultaneous valid lanes; behaviour in that case is undefined.

Candidate selection and filtering:
- A candidate is any lane with in_valid and in_mispred that survives filtering.
- The selected mispredict is the oldest candidate. On an age tie, the lower lane wins (defensive only).
- A lane survives filtering if it is not younger than the selected mispredict of this cycle.
- In RECOVER or DRAIN, a lane must also be older than the stored age to survive.
- Non-surviving lanes produce out_valid=0 next cycle. Their other out_* fields are don't-care.
- Surviving lanes pass all fields through unchanged.
- The selected mispredict itself survives, so its PHT entry is updated.

Recovery history:
- Conditional branch: {gh[GH_WIDTH-2:0], exec_taken}.
- Otherwise: gh unchanged.

FSM (states IDLE, RECOVER, DRAIN):
- IDLE: a candidate exists -> RECOVER. Store its age, register recover_valid=1 and recover_history.
- RECOVER: lasts one cycle with recover_valid=1.
  - A candidate older than the stored age -> stay in RECOVER, update the stored age, pulse again next cycle.
  - Otherwise -> DRAIN.
- DRAIN: recover_valid=0.
  - A candidate older than the stored age -> RECOVER.
  - Else flush_done -> IDLE.
  - Older candidate and flush_done in the same cycle: RECOVER wins and flush_done is ignored.
- flush_done is ignored in IDLE and RECOVER.

Other rules:
- recovering = (state != IDLE), registered.
- recover_count increments on each recover_valid pulse and saturates at 16'hFFFF.
- Age wrap-around relies solely on the circular compare; there is no special casing.
- Reset asserted mid-recovery aborts immediately: no further pulse, and out_valid is 0 from reset onward.

Test Plan:
1. Reset, then lane0 valid, not mispredicted, idx=0x155, prev=2, taken=1 -> next cycle out_valid=01, out_pht_idx lane0=0x155, recover_valid=0, recovering=0.
2. IDLE, lane1 cond mispred, gh=0x2A5, taken=0, age=10; lane0 valid non-mispred, age=12 -> next cycle recover_valid=1, recover_history=0x14A, out_valid=10; then recovering=1 and recover_count=1.
3. Both lanes cond mispred, ages 5 (lane1) and 7 (lane0) -> lane1 selected, out_valid=10, a single pulse with lane1's history.
4. DRAIN with stored age 20; input mispred age 18 and flush_done in the same cycle -> state RECOVER, second pulse, stored age 18, recover_count=2; a later valid result with age 19 is dropped (out_valid=0).
5. Age wrap: stored age 126 in DRAIN; result age 1 (younger) dropped; result age 125 forwarded; flush_done -> IDLE, recovering=0 one cycle later.
6. Assert rst_n=0 in RECOVER -> recover_valid, out_valid and recovering read 0 immediately (asynchronously), before any clock edge; after release, state is IDLE and recover_count=0.
